// File: rtl/tb_run_monitor.sv
// Run/progress monitor: tracks per-lane retires and the GPIO/LED bus,
// emits periodic report strobes and latches a sticky test verdict
// (pass, fail, hang or timeout).
module tb_run_monitor #(
  parameter int                NUM_CH          = 2,
  parameter int                PC_W            = 32,
  parameter int                GPIO_W          = 6,
  parameter int                CNT_W           = 32,
  parameter int                REPORT_INTERVAL = 10000,
  parameter int                HANG_CYCLES     = 100000,
  parameter int                TIMEOUT_CYCLES  = 60000000,
  parameter logic [GPIO_W-1:0] PASS_PATTERN    = GPIO_W'(6'h3F),
  parameter logic [GPIO_W-1:0] FAIL_PATTERN    = GPIO_W'(6'h15),
  parameter int                SIG_HOLD        = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [NUM_CH-1:0]      wb_valid,
  input  logic [NUM_CH*PC_W-1:0] wb_pc,
  input  logic [GPIO_W-1:0]      gpio,
  output logic                   report_stb,
  output logic [NUM_CH*PC_W-1:0] report_pc,
  output logic [GPIO_W-1:0]      report_gpio,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic [2:0]             state,
  output logic                   done
);

  // Counter widths sized to just hold their terminal values.
  localparam int INT_W  = $clog2(REPORT_INTERVAL + 1);
  localparam int IDLE_W = $clog2(HANG_CYCLES + 1);
  localparam int HOLD_W = $clog2(SIG_HOLD + 1);
  localparam int POP_W  = $clog2(NUM_CH + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_HANG    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cycle_reg, cycle_next;
  logic [CNT_W-1:0]    retire_reg, retire_next;
  logic [INT_W-1:0]    int_reg, int_next;
  logic [IDLE_W-1:0]   idle_reg, idle_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic                stb_reg, stb_next;
  logic [GPIO_W-1:0]   rgpio_reg, rgpio_next;
  logic [GPIO_W-1:0]   prev_gpio_reg;

  logic [POP_W-1:0]    pop_cnt;
  logic [CNT_W:0]      retire_sum;
  logic [CNT_W-1:0]    retire_sat;
  logic [CNT_W-1:0]    cycle_inc;
  logic [INT_W-1:0]    int_inc;
  logic [IDLE_W-1:0]   idle_inc;
  logic [HOLD_W-1:0]   hold_inc;
  logic                any_valid;
  logic                sig_match;
  logic                sig_done;
  logic                hang_hit;
  logic                tmo_hit;
  logic                lane_upd;

  // Number of lanes retiring this cycle.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop_cnt = pop_cnt + POP_W'(wb_valid[i]);
    end
  end

  assign any_valid  = |wb_valid;
  assign retire_sum = {1'b0, retire_reg} + (CNT_W+1)'(pop_cnt);
  assign retire_sat = retire_sum[CNT_W] ? {CNT_W{1'b1}} : retire_sum[CNT_W-1:0];
  assign cycle_inc  = cycle_reg + CNT_W'(1);
  assign int_inc    = int_reg + INT_W'(1);
  assign idle_inc   = idle_reg + IDLE_W'(1);
  assign hold_inc   = hold_reg + HOLD_W'(1);

  // A signature only counts while it is both stable and one of the two patterns.
  assign sig_match = (gpio == prev_gpio_reg) &&
                     ((gpio == PASS_PATTERN) || (gpio == FAIL_PATTERN));
  assign sig_done  = sig_match && (hold_inc == HOLD_W'(SIG_HOLD));
  assign hang_hit  = !any_valid && (idle_inc == IDLE_W'(HANG_CYCLES));
  assign tmo_hit   = (cycle_inc == CNT_W'(TIMEOUT_CYCLES));
  assign lane_upd  = (state_reg == ST_RUN) && !clear;

  // Next-state and counter update; clear overrides everything else.
  always_comb begin
    state_next  = state_reg;
    cycle_next  = cycle_reg;
    retire_next = retire_reg;
    int_next    = int_reg;
    idle_next   = idle_reg;
    hold_next   = hold_reg;
    stb_next    = 1'b0;
    rgpio_next  = rgpio_reg;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next  = ST_RUN;
            cycle_next  = '0;
            retire_next = '0;
            int_next    = '0;
            idle_next   = '0;
            hold_next   = '0;
          end
        end
        ST_RUN: begin
          cycle_next  = cycle_inc;
          retire_next = retire_sat;
          if (int_inc == INT_W'(REPORT_INTERVAL)) begin
            int_next   = '0;
            stb_next   = 1'b1;
            rgpio_next = gpio;
          end else begin
            int_next = int_inc;
          end
          idle_next = any_valid ? '0 : idle_inc;
          hold_next = sig_match ? hold_inc : '0;
          if (sig_done && (gpio == FAIL_PATTERN)) begin
            state_next = ST_FAIL;
          end else if (sig_done) begin
            state_next = ST_PASS;
          end else if (hang_hit) begin
            state_next = ST_HANG;
          end else if (tmo_hit) begin
            state_next = ST_TIMEOUT;
          end
        end
        ST_PASS, ST_FAIL, ST_HANG, ST_TIMEOUT: begin
          state_next = state_reg;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      cycle_reg     <= '0;
      retire_reg    <= '0;
      int_reg       <= '0;
      idle_reg      <= '0;
      hold_reg      <= '0;
      stb_reg       <= 1'b0;
      rgpio_reg     <= '0;
      prev_gpio_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cycle_reg     <= cycle_next;
      retire_reg    <= retire_next;
      int_reg       <= int_next;
      idle_reg      <= idle_next;
      hold_reg      <= hold_next;
      stb_reg       <= stb_next;
      rgpio_reg     <= rgpio_next;
      prev_gpio_reg <= gpio;
    end
  end

  // Per-lane last retired PC; survives start and clear, only reset wipes it.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    logic [PC_W-1:0] pc_reg;

    // Capture the lane PC whenever the lane retires during RUN.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pc_reg <= '0;
      end else if (lane_upd && wb_valid[gi]) begin
        pc_reg <= wb_pc[gi*PC_W +: PC_W];
      end
    end

    assign report_pc[gi*PC_W +: PC_W] = pc_reg;
  end

  assign report_stb  = stb_reg;
  assign report_gpio = rgpio_reg;
  assign cycle_cnt   = cycle_reg;
  assign retire_cnt  = retire_reg;
  assign state       = state_reg;
  assign done        = (state_reg == ST_PASS) || (state_reg == ST_FAIL) ||
                       (state_reg == ST_HANG) || (state_reg == ST_TIMEOUT);

endmodule

// File: doc/tb_run_monitor.md
Name: tb_run_monitor

Overview:
- Parametrised run/progress monitor for SoC simulation and FPGA bring-up.
- Watches per-lane write-back retire signals and the GPIO/LED output bus.
- Emits periodic report strobes with PC/LED snapshots and decides the test verdict: pass, fail, hang or timeout.
- Generalises the fixed-interval PC/LED printout and the fixed timeout to N retire lanes, LED pass/fail signatures and hang detection, with all verdicts visible as registered outputs.

Parameters:
- NUM_CH, 2, number of retire lanes monitored.
- PC_W, 32, PC width per lane.
- GPIO_W, 6, LED/GPIO output width.
- CNT_W, 32, width of cycle and retire counters.
- REPORT_INTERVAL, 10000, run cycles between report strobes (≥1).
- HANG_CYCLES, 100000, consecutive cycles with no retire on any lane that declares a hang (≥1).
- TIMEOUT_CYCLES, 60000000, run cycles before timeout (≥1).
- PASS_PATTERN, 6'h3F, GPIO value signalling pass.
- FAIL_PATTERN, 6'h15, GPIO value signalling fail; must differ from PASS_PATTERN.
- SIG_HOLD, 16, consecutive cycles a pattern must be stable before it is accepted (≥1).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  arm pulse; IDLE->RUN.
- clear  in  1  synchronous return to IDLE from any state.
- wb_valid  in  NUM_CH  per-lane retire valid.
- wb_pc  in  NUM_CH*PC_W  per-lane retired PC; lane i at [i*PC_W +: PC_W].
- gpio  in  GPIO_W  LED/GPIO bus under observation.
- report_stb  out  1  one-cycle report pulse.
- report_pc  out  NUM_CH*PC_W  last retired PC per lane.
- report_gpio  out  GPIO_W  gpio sampled at the report.
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- retire_cnt  out  CNT_W  total retires, saturating.
- state  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 HANG, 5 TIMEOUT.
- done  out  1  state is PASS, FAIL, HANG or TIMEOUT.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; all counters, report_pc, report_gpio, report_stb=0; done=0; all internal counters cleared.
- IDLE: counters hold. start=1 -> RUN next cycle, clearing cycle_cnt, retire_cnt, idle and hold counters; report_pc is not cleared.
- RUN, every cycle:
  - cycle_cnt +1.
  - retire_cnt += popcount(wb_valid), saturating at all-ones.
  - For each lane with wb_valid[i]=1, last_pc[i] <= wb_pc lane i. Invalid lanes keep their value.
  - report_pc is the live last_pc.
- Report: an internal interval counter counts RUN cycles. On the cycle it reaches REPORT_INTERVAL, it wraps to 0, report_stb=1 for exactly one cycle, and report_gpio <= gpio. First strobe is REPORT_INTERVAL cycles after entering RUN.
- Hang: idle counter resets on any wb_valid bit set, else increments. Reaching HANG_CYCLES -> HANG.
- Signature:
  - Hold counter increments while gpio equals the previous-cycle gpio and equals PASS_PATTERN or FAIL_PATTERN; otherwise it resets to 0.
  - Hold counter reaching SIG_HOLD -> PASS or FAIL according to the pattern held.
- Timeout: cycle_cnt reaching TIMEOUT_CYCLES -> TIMEOUT.
- Simultaneous terminal conditions in one cycle: priority FAIL > PASS > HANG > TIMEOUT.
- Terminal states are sticky:
  - Counters freeze and report_stb stays 0.
  - done=1 one cycle after the triggering condition (registered state).
  - Only clear or reset leaves a terminal state.
- clear has priority over start and over all RUN transitions. It returns to IDLE without clearing report_pc.
- start is ignored outside IDLE.
- Reset asserted mid-RUN aborts immediately to IDLE with all outputs at reset values.

Test Plan:
- Reset, start, one lane retiring PC 0x1C000000+4k each cycle, REPORT_INTERVAL=100 -> report_stb pulses exactly at RUN cycles 100, 200, 300. report_pc lane0 holds the latest PC; retire_cnt=cycle_cnt.
- Both lanes valid every cycle with distinct PCs; lane1 valid on alternate cycles only -> retire_cnt grows by 2/1 alternately. Lane1's report_pc holds its last valid PC.
- gpio=PASS_PATTERN for SIG_HOLD-1 cycles, glitch, then SIG_HOLD cycles -> no verdict after the first run; state=PASS, done=1 after the second. Counters then frozen.
- wb_valid=0 for HANG_CYCLES=50 with TIMEOUT_CYCLES=50 coinciding -> state=HANG (priority over TIMEOUT). clear -> IDLE; start -> RUN with counters 0.
- FAIL_PATTERN hold completing on the same cycle as a hang -> state=FAIL.
- Reset_n pulsed low mid-RUN (asynchronous, between clock edges) -> outputs zero immediately. start with clear in the same cycle -> stays IDLE.
